io_display_controller: RTL and testbench

//   Memory-mapped board display peripheral on the core's io_* bus: red/green LEDs,
//   NUM_HEX seven-segment digits, per-digit hex decode, blink and cycle counter.

---
 rtl/io_display_controller.sv | 148 ++++++++++++++
 tb/tb_io_display_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_display_controller.sv
// Memory-mapped LED / seven-segment display peripheral on the io_* bus.
// Registered readback, per-digit hex decode, blink and free-running counter.
module io_display_controller #(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          NUM_RED      = 18,
  parameter int          NUM_GREEN    = 9,
  parameter int          NUM_HEX      = 4,
  parameter int          BLINK_DIVIDE = 25000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   io_write_en,
  input  logic                   io_read_en,
  input  logic [31:0]            io_address,
  input  logic [31:0]            io_write_data,
  output logic [31:0]            io_read_data,
  output logic [NUM_RED-1:0]     red_led,
  output logic [NUM_GREEN-1:0]   green_led,
  output logic [7*NUM_HEX-1:0]   hex
);

  localparam int PW = $clog2(BLINK_DIVIDE);
  localparam logic [PW-1:0] PMAX = PW'(BLINK_DIVIDE - 1);

  localparam logic [31:0] A_RED   = 32'h00;
  localparam logic [31:0] A_GREEN = 32'h04;
  localparam logic [31:0] A_MODE  = 32'h28;
  localparam logic [31:0] A_BLINK = 32'h2C;
  localparam logic [31:0] A_CYC   = 32'h30;

  logic [NUM_RED-1:0]   red_q;
  logic [NUM_GREEN-1:0] green_q;
  logic [6:0]           hex_q [NUM_HEX];
  logic [NUM_HEX-1:0]   mode_q;
  logic [NUM_HEX-1:0]   bhex_q;
  logic                 bred_q;
  logic                 bgreen_q;
  logic [31:0]          cycles_q;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 phase_q, phase_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          off;
  logic                 wr_blink;
  logic                 unused_wdata;

  assign off          = io_address - BASE_ADDR;
  assign wr_blink     = io_write_en && (off == A_BLINK);
  assign io_read_data = rdata_q;
  assign unused_wdata = ^io_write_data;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A BLINK write restarts the blink period from a visible phase.
  always_comb begin
    presc_d = presc_q + PW'(1);
    phase_d = phase_q;
    if (wr_blink) begin
      presc_d = '0;
      phase_d = 1'b0;
    end else if (presc_q == PMAX) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    rdata_d = 32'h0;
    case (off)
      A_RED:   rdata_d = 32'(red_q);
      A_GREEN: rdata_d = 32'(green_q);
      A_MODE:  rdata_d = 32'(mode_q);
      A_BLINK: rdata_d = {14'h0, bgreen_q, bred_q, 16'(bhex_q)};
      A_CYC:   rdata_d = cycles_q;
      default: rdata_d = 32'h0;
    endcase
    for (int i = 0; i < NUM_HEX; i++)
      if (off == 32'(8 + 4 * i)) rdata_d = 32'(hex_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      red_q    <= '0;
      green_q  <= '0;
      mode_q   <= '0;
      bhex_q   <= '0;
      bred_q   <= 1'b0;
      bgreen_q <= 1'b0;
      cycles_q <= 32'h0;
      presc_q  <= '0;
      phase_q  <= 1'b0;
      rdata_q  <= 32'h0;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= 7'h7F;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      if (io_read_en) rdata_q <= rdata_d;
      if (io_write_en) begin
        if (off == A_RED)   red_q   <= io_write_data[NUM_RED-1:0];
        if (off == A_GREEN) green_q <= io_write_data[NUM_GREEN-1:0];
        if (off == A_MODE)  mode_q  <= io_write_data[NUM_HEX-1:0];
        if (off == A_BLINK) begin
          bhex_q   <= io_write_data[NUM_HEX-1:0];
          bred_q   <= io_write_data[16];
          bgreen_q <= io_write_data[17];
        end
        for (int i = 0; i < NUM_HEX; i++)
          if (off == 32'(8 + 4 * i)) hex_q[i] <= io_write_data[6:0];
      end
    end
  end

  always_comb begin
    red_led   = (phase_q && bred_q) ? '0 : red_q;
    green_led = (phase_q && bgreen_q) ? '0 : green_q;
    hex       = '0;
    for (int i = 0; i < NUM_HEX; i++) begin
      if (phase_q && bhex_q[i])
        hex[7*i +: 7] = 7'h7F;
      else if (mode_q[i])
        hex[7*i +: 7] = seg(hex_q[i][3:0]);
      else
        hex[7*i +: 7] = hex_q[i];
    end
  end

endmodule

// File: tb/tb_io_display_controller.sv
// Scoreboard bench for io_display_controller: directed cases plus random
// bus traffic against a register-map / elapsed-time reference model.
module tb_io_display_controller;

  localparam int NR = 18;
  localparam int NG = 9;
  localparam int NH = 4;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          io_write_en = 1'b0;
  logic          io_read_en = 1'b0;
  logic [31:0]   io_address = 32'h0;
  logic [31:0]   io_write_data = 32'h0;
  logic [31:0]   io_read_data;
  logic [NR-1:0] red_led;
  logic [NG-1:0] green_led;
  logic [7*NH-1:0] hex;

  io_display_controller #(
    .BASE_ADDR(32'h0), .NUM_RED(NR), .NUM_GREEN(NG),
    .NUM_HEX(NH), .BLINK_DIVIDE(BD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_address(io_address), .io_write_data(io_write_data),
    .io_read_data(io_read_data),
    .red_led(red_led), .green_led(green_led), .hex(hex)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  logic [NR-1:0] m_red;
  logic [NG-1:0] m_green;
  logic [6:0]    m_hex [NH];
  logic [NH-1:0] m_mode;
  logic [NH-1:0] m_bhex;
  logic          m_bred, m_bgreen;
  logic [31:0]   m_cyc;
  int            m_since;
  logic [31:0]   m_rd;
  logic [31:0]   sb [$];
  logic          rd_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == 32'h00) return 32'(m_red);
    if (a == 32'h04) return 32'(m_green);
    if (a == 32'h28) return 32'(m_mode);
    if (a == 32'h2C) return {14'h0, m_bgreen, m_bred, 12'h0, m_bhex};
    if (a == 32'h30) return m_cyc;
    if (a >= 32'h08 && a < 32'(8 + 4 * NH) && a[1:0] == 2'b00)
      return 32'(m_hex[int'((a - 32'h8) / 4)]);
    return 32'h0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'h00) m_red = d[NR-1:0];
    else if (a == 32'h04) m_green = d[NG-1:0];
    else if (a == 32'h28) m_mode = d[NH-1:0];
    else if (a == 32'h2C) begin
      m_bhex = d[NH-1:0];
      m_bred = d[16];
      m_bgreen = d[17];
      m_since = -1;
    end else if (a >= 32'h08 && a < 32'(8 + 4 * NH) && a[1:0] == 2'b00)
      m_hex[int'((a - 32'h8) / 4)] = d[6:0];
  endtask

  task automatic m_reset();
    m_red = '0; m_green = '0; m_mode = '0; m_bhex = '0;
    m_bred = 1'b0; m_bgreen = 1'b0;
    m_cyc = 32'h0; m_since = 0; m_rd = 32'h0;
    for (int i = 0; i < NH; i++) m_hex[i] = 7'h7F;
  endtask

  // One bus cycle: drive after negedge, DUT samples at posedge.
  task automatic cyc(input logic we, input logic re,
                     input logic [31:0] a, input logic [31:0] d);
    io_write_en = we;
    io_read_en = re;
    io_address = a;
    io_write_data = d;
    if (reset_n) begin
      if (re) begin
        m_rd = m_read(a);
        sb.push_back(m_rd);
      end
      if (we) m_write(a, d);
    end
    @(posedge clk);
    if (!reset_n) m_reset();
    else begin
      m_cyc = m_cyc + 32'd1;
      m_since = m_since + 1;
    end
    @(negedge clk);
    io_write_en = 1'b0;
    io_read_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_out();
    logic ph;
    logic [6:0] dg;
    ph = ((m_since / BD) % 2) == 1;
    check("red_led", 32'(red_led), (ph && m_bred) ? 32'h0 : 32'(m_red));
    check("green_led", 32'(green_led),
          (ph && m_bgreen) ? 32'h0 : 32'(m_green));
    for (int i = 0; i < NH; i++) begin
      if (ph && m_bhex[i]) dg = 7'h7F;
      else if (m_mode[i]) dg = SEG[m_hex[i][3:0]];
      else dg = m_hex[i];
      check($sformatf("hex%0d", i), 32'(hex[7*i +: 7]), 32'(dg));
    end
    check("rdata_hold", io_read_data, m_rd);
  endtask

  // Monitor: read data is due on the cycle after an accepted strobe.
  always @(posedge clk) rd_pend <= io_read_en && reset_n;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got %h expected none", io_read_data);
      end else begin
        check("read", io_read_data, sb.pop_front());
      end
    end
  end

  logic [31:0] addrs [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                              32'h14, 32'h18, 32'h1C, 32'h28, 32'h2C,
                              32'h30, 32'h34, 32'h40};

  initial begin
    m_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle(2);
    chk_out();
    reset_n = 1'b1;

    // Full-width write truncated to 18 red bits
    cyc(1'b1, 1'b0, 32'h00, 32'hFFFFFFFF);
    chk_out();
    check("red_all", 32'(red_led), 32'h0003FFFF);
    cyc(1'b0, 1'b1, 32'h00, 32'h0);
    check("red_rd", io_read_data, 32'h0003FFFF);

    // Decode vs raw digits, out-of-range digit ignored
    cyc(1'b1, 1'b0, 32'h28, 32'h1);
    cyc(1'b1, 1'b0, 32'h08, 32'hF);
    cyc(1'b1, 1'b0, 32'h0C, 32'h12);
    cyc(1'b1, 1'b0, 32'h1C, 32'h55);
    chk_out();
    check("dig0", 32'(hex[6:0]), 32'h0E);
    check("dig1", 32'(hex[13:7]), 32'h12);
    cyc(1'b0, 1'b1, 32'h1C, 32'h0);
    idle(1);

    // Blink red with RED=1
    cyc(1'b1, 1'b0, 32'h00, 32'h1);
    cyc(1'b1, 1'b0, 32'h2C, 32'h10000);
    for (int i = 0; i < 16; i++) begin
      chk_out();
      idle(1);
    end
    cyc(1'b1, 1'b0, 32'h2C, 32'h0);

    // Same-cycle read and write returns the old value
    cyc(1'b1, 1'b0, 32'h04, 32'h3);
    cyc(1'b1, 1'b1, 32'h04, 32'h5);
    check("rw_old", io_read_data, 32'h3);
    cyc(1'b0, 1'b1, 32'h04, 32'h0);
    check("rw_new", io_read_data, 32'h5);

    // Counter distance and wrap
    cyc(1'b0, 1'b1, 32'h30, 32'h0);
    idle(7);
    cyc(1'b0, 1'b1, 32'h30, 32'h0);
    cyc(1'b1, 1'b0, 32'h30, 32'h1234);
    force dut.cycles_q = 32'hFFFFFFFD;
    #1;
    release dut.cycles_q;
    m_cyc = 32'hFFFFFFFD;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'h30, 32'h0);
    check("wrapped", io_read_data, 32'h1);

    // Reset during a read strobe
    cyc(1'b0, 1'b1, 32'h04, 32'h0);
    reset_n = 1'b0;
    cyc(1'b0, 1'b1, 32'h04, 32'h0);
    reset_n = 1'b1;
    check("rst_rd", io_read_data, 32'h0);
    chk_out();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = addrs[$urandom_range(0, 12)];
      reset_n = ($urandom_range(0, 99) != 0);
      cyc(1'($urandom), 1'($urandom), a, $urandom);
      reset_n = 1'b1;
      chk_out();
    end
    idle(2);
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
